// File: rtl/demux1x16_capture_pkg.sv
// Shared types and defaults for the 16:1 mux receive path.
package demux1x16_capture_pkg;

  localparam int N_DEF = 16;
  localparam int M_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/demux1x16_capture_idx_counter.sv
// Slot index counter: synchronous clear, count enable, wrap flag on the last slot.
module idx_counter #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [M-1:0] cnt,
  output logic         wrap
);

  // Last slot is all ones because the slot count is a power of two.
  assign wrap = (cnt == {M{1'b1}});

  // Clear wins over enable; natural rollover gives the mod-N wrap.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/demux1x16_capture.sv
// Receive end of the 16:1 mux path: drives the remote select, steers each
// returned serial bit into its slot, and presents the word on valid/ready.
module demux1x16_capture
  import demux1x16_capture_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         din,
  input  logic         din_valid,
  output logic [M-1:0] sel_out,
  output logic         busy,
  output logic [N-1:0] word,
  output logic         word_valid,
  input  logic         word_ready,
  output logic         overrun
);

  state_t         state, state_nx;
  logic [N-1:0]   shadow;
  logic [M-1:0]   idx;
  logic           wrap;
  logic           cnt_clr, cnt_en;
  logic           cap, done, start_idle;

  idx_counter #(.M(M)) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (idx),
    .wrap (wrap)
  );

  // Select is taken straight from the counter register, so it never glitches.
  assign sel_out = idx;
  assign busy    = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx   = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cap        = 1'b0;
    done       = 1'b0;
    start_idle = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx   = ST_CAPTURE;
          cnt_clr    = 1'b1;
          start_idle = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Restart beats a coincident data bit.
        if (start) begin
          cnt_clr = 1'b1;
        end else if (din_valid) begin
          cnt_en = 1'b1;
          cap    = 1'b1;
          if (wrap) begin
            state_nx = ST_HOLD;
            done     = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (word_valid && word_ready) begin
          if (start) begin
            state_nx = ST_CAPTURE;
            cnt_clr  = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Shadow register: cleared at frame setup, one slot written per valid bit.
  always_ff @(posedge clk) begin
    if (rst)          shadow      <= '0;
    else if (cnt_clr) shadow      <= '0;
    else if (cap)     shadow[idx] <= din;
  end

  // Output word: the last bit bypasses the shadow so the word lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst)       word <= '0;
    else if (done) word <= {din, shadow[N-2:0]};
  end

  // Output valid: set on frame completion, dropped after the handshake.
  always_ff @(posedge clk) begin
    if (rst)                            word_valid <= 1'b0;
    else if (done)                      word_valid <= 1'b1;
    else if (word_valid && word_ready)  word_valid <= 1'b0;
  end

  // Sticky overrun: a bit arrived while the word was still waiting; only a
  // fresh start from idle clears it.
  always_ff @(posedge clk) begin
    if (rst)                                  overrun <= 1'b0;
    else if (start_idle)                      overrun <= 1'b0;
    else if (state == ST_HOLD && din_valid)   overrun <= 1'b1;
  end

endmodule
